// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: flags the last PAT_LEN accepted bits matching PATTERN.
// Supports overlap/restart detection, one-shot lock and a saturating match counter.
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             one_shot,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             match,
    output logic             locked,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int               SW        = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0]    SEEN_FULL = SW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HUNT   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             r_state;
    logic [PAT_LEN-1:0] r_hist;
    logic [SW-1:0]      r_seen;
    logic               r_match;
    logic               r_locked;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [PAT_LEN-1:0] w_hist_n;
    logic [SW-1:0]      w_seen_n;
    logic               w_detect;
    logic [CNT_W-1:0]   w_cnt_n;

    assign w_accept = (r_state == S_HUNT) & in_valid & ~clr & en;
    assign w_hist_n = {r_hist[PAT_LEN-2:0], in_bit};
    assign w_seen_n = (r_seen == SEEN_FULL) ? r_seen : r_seen + 1'b1;
    assign w_detect = w_accept & (w_seen_n == SEEN_FULL) & (w_hist_n == PATTERN);
    assign w_cnt_n  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hist   <= '0;
            r_seen   <= '0;
            r_match  <= 1'b0;
            r_locked <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_state  <= en ? S_HUNT : S_IDLE;
            r_hist   <= '0;
            r_seen   <= '0;
            r_match  <= 1'b0;
            r_locked <= 1'b0;
            r_cnt    <= '0;
        end else if (!en) begin
            // Disable drops history but keeps the match count.
            r_state  <= S_IDLE;
            r_hist   <= '0;
            r_seen   <= '0;
            r_match  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_match <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_HUNT;
                end
                S_HUNT: begin
                    if (w_detect) begin
                        r_match <= 1'b1;
                        r_cnt   <= w_cnt_n;
                        if (OVERLAP) begin
                            r_hist <= w_hist_n;
                            r_seen <= SEEN_FULL;
                        end else begin
                            r_hist <= '0;
                            r_seen <= '0;
                        end
                        if (one_shot) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_accept) begin
                        r_hist <= w_hist_n;
                        r_seen <= w_seen_n;
                    end
                end
                S_LOCKED: begin
                    r_locked <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign match     = r_match;
    assign locked    = r_locked;
    assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: three parameter sets share one stimulus
// stream and are compared each cycle against a queue-based reference.
module tb_seq_pattern_detector;

    localparam int       L   = 4;
    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic rst, en, clr, one_shot, in_valid, in_bit;
    logic m_a, m_b, m_c;
    logic l_a, l_b, l_c;
    logic [7:0] c_a, c_b;
    logic [1:0] c_c;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .one_shot(one_shot),
        .in_valid(in_valid), .in_bit(in_bit),
        .match(m_a), .locked(l_a), .match_cnt(c_a));

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .one_shot(one_shot),
        .in_valid(in_valid), .in_bit(in_bit),
        .match(m_b), .locked(l_b), .match_cnt(c_b));

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .one_shot(one_shot),
        .in_valid(in_valid), .in_bit(in_bit),
        .match(m_c), .locked(l_c), .match_cnt(c_c));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: per instance, the accepted bits since last restart.
    bit mq [3][$];
    int m_cnt [3];
    bit m_match [3];
    bit m_lock [3];
    bit m_hunt [3];
    int cw [3] = '{8, 8, 2};
    bit ov [3] = '{1'b1, 1'b0, 1'b1};

    function automatic bit tail_hit(input int k);
        logic [3:0] p;
        p = PAT;
        if (mq[k].size() != L) return 1'b0;
        for (int i = 0; i < L; i++)
            if (mq[k][i] != p[L-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit c,
                              input bit os, input bit v, input bit b);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                mq[k].delete(); m_cnt[k] = 0; m_match[k] = 0;
                m_lock[k] = 0; m_hunt[k] = 0;
            end else if (c) begin
                mq[k].delete(); m_cnt[k] = 0; m_match[k] = 0;
                m_lock[k] = 0; m_hunt[k] = e;
            end else if (!e) begin
                mq[k].delete(); m_match[k] = 0;
                m_lock[k] = 0; m_hunt[k] = 0;
            end else if (m_lock[k]) begin
                m_match[k] = 0;
            end else if (!m_hunt[k]) begin
                m_hunt[k] = 1; m_match[k] = 0;
            end else begin
                m_match[k] = 0;
                if (v) begin
                    mq[k].push_back(b);
                    if (mq[k].size() > L) void'(mq[k].pop_front());
                    if (tail_hit(k)) begin
                        m_match[k] = 1;
                        if (m_cnt[k] < (1 << cw[k]) - 1) m_cnt[k]++;
                        if (!ov[k]) mq[k].delete();
                        if (os) begin
                            m_lock[k] = 1; m_hunt[k] = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit c,
                       input bit os, input bit v, input bit b);
        rst = r; en = e; clr = c; one_shot = os; in_valid = v; in_bit = b;
        @(posedge clk);
        model_step(r, e, c, os, v, b);
        #1;
        chk("match_a",  32'(m_a), 32'(m_match[0]));
        chk("match_b",  32'(m_b), 32'(m_match[1]));
        chk("match_c",  32'(m_c), 32'(m_match[2]));
        chk("locked_a", 32'(l_a), 32'(m_lock[0]));
        chk("locked_b", 32'(l_b), 32'(m_lock[1]));
        chk("locked_c", 32'(l_c), 32'(m_lock[2]));
        chk("cnt_a",    32'(c_a), 32'(m_cnt[0]));
        chk("cnt_b",    32'(c_b), 32'(m_cnt[1]));
        chk("cnt_c",    32'(c_c), 32'(m_cnt[2]));
    endtask

    task automatic feed(input logic [7:0] bits, input int n, input bit os);
        for (int i = n - 1; i >= 0; i--) cyc(0, 1, 0, os, 1, bits[i]);
    endtask

    int pulses;

    initial begin
        rst = 1; en = 0; clr = 0; one_shot = 0; in_valid = 0; in_bit = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 1);
        chk("rst_cnt_a", 32'(c_a), 0);

        // T1/T2: overlapping vs restarting detection
        cyc(0, 1, 0, 0, 0, 0);
        feed(8'b0101_1011, 7, 0);
        chk("t1_cnt_ovl", 32'(c_a), 2);
        chk("t2_cnt_novl", 32'(c_b), 1);
        cyc(0, 1, 1, 0, 0, 0);

        // T3: one-shot lock then clear
        feed(8'b1011_1011, 8, 1);
        chk("t3_locked", 32'(l_a), 1);
        chk("t3_cnt", 32'(c_a), 1);
        cyc(0, 1, 1, 0, 0, 0);
        chk("t3_clr_locked", 32'(l_a), 0);
        chk("t3_clr_cnt", 32'(c_a), 0);

        // T4: valid gaps are transparent, disable wipes history
        feed(8'b10, 2, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0);
        feed(8'b11, 2, 0);
        chk("t4_gap_match", 32'(m_a), 1);
        cyc(0, 1, 1, 0, 0, 0);
        feed(8'b10, 2, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        feed(8'b11, 2, 0);
        chk("t4_en_nomatch", 32'(m_a), 0);

        // T5: saturating 2-bit counter still pulses match
        cyc(0, 1, 1, 0, 0, 0);
        pulses = 0;
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 1, 0, 0, 1, PAT[i]);
            if (m_c) pulses++;
        end
        for (int r = 0; r < 4; r++) begin
            for (int i = 2; i >= 0; i--) begin
                cyc(0, 1, 0, 0, 1, PAT[i]);
                if (m_c) pulses++;
            end
        end
        chk("t5_pulses", 32'(pulses), 5);
        chk("t5_sat", 32'(c_c), 3);

        // T6: clr on completing bit, reset mid-stream
        cyc(0, 1, 1, 0, 0, 0);
        feed(8'b101, 3, 0);
        cyc(0, 1, 1, 0, 1, 1);
        chk("t6_clr_match", 32'(m_a), 0);
        chk("t6_clr_cnt", 32'(c_a), 0);
        feed(8'b101, 3, 0);
        cyc(1, 1, 0, 0, 1, 1);
        chk("t6_rst_match", 32'(m_a), 0);
        cyc(0, 1, 0, 0, 1, 1);
        chk("t6_straddle", 32'(m_a), 0);

        // Random traffic against the reference
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 300) == 0,
                ($urandom % 40) != 0,
                ($urandom % 80) == 0,
                ($urandom % 6) == 0,
                ($urandom % 5) != 0,
                1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
